mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the CPU's data-memory write port. Snoops `write_enab`, `data_addr` and `write_data` from the mother board. Each store to `TX_ADDR` queues the low byte into a small FIFO, and a serializer FSM shifts the queued bytes out on `tx` as 8N1 frames. It is the first device downstream of the data bus, used to turn program stores into observable serial output.

## Interface
Parameters:
- `TX_ADDR`, 32'h0000_FF00: full 32-bit store address that enqueues a byte.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range is 2 or greater.
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of two, 2 or greater.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `write_enab`  in  1  data-memory store strobe from the mother board.
- `data_addr`  in  32  data-memory address.
- `write_data`  in  32  store data; only bits [7:0] are used.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in flight or the FIFO is non-empty.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `drop_cnt`  out  8  saturating count of stores dropped because the FIFO was full.

## Operation
- Push:
  - A push is a rising edge with `write_enab` = 1 and `data_addr` == `TX_ADDR`; it enqueues `write_data[7:0]`.
  - Other addresses, and cycles with `write_enab` = 0, are ignored.
- Overflow:
  - If the FIFO is full and no pop happens in the same cycle, the byte is discarded.
  - In that case `drop_cnt` increments and saturates at 8'hFF.
- Simultaneous push and pop:
  - Full FIFO: the push is accepted and the count stays unchanged.
  - Empty FIFO: no pop occurs that cycle; the byte is popped next cycle.
- FSM states are IDLE, START, DATA, STOP (and PARITY when enabled).
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7. After bit 7, go to STOP (or PARITY).
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, clears on every state change, and advances the bit when it reaches terminal count.
- FIFO pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is one bit wider.
- `busy` = (state != IDLE) || (count != 0).

## Timing
- Reset values: `tx` = 1, `busy` = 0, `fifo_full` = 0, `drop_cnt` = 0, FIFO empty, state IDLE, counters 0.
- Reset mid-frame: the frame is abandoned, `tx` is high after the reset edge, and queued bytes are flushed.
- Latency from a store on edge t into an empty, idle block:
  - Pop occurs on edge t+1.
  - `tx` falls after edge t+2.
- Frame length: 10×`CLKS_PER_BIT` cycles (11× with parity).
- Back-to-back frames have exactly one IDLE cycle (`tx` high) between the end of STOP and the next START.
- `fifo_full` and `drop_cnt` are registered and update on the edge that changes the count.

## Configuration
- `MMIO_UART_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
- `MMIO_UART_PARITY_EN` undefined: the PARITY state and its logic are absent, and frames are 8N1.

## Structure
- Package `mmio_pkg` holds:
  - the `TX_ADDR` default constant;
  - the `uart_state_e` enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS` = 8.
- Sub-module `sync_fifo` provides the byte queue:
  - parameters: width and depth;
  - ports: push, pop, din, dout, full, empty, count;
  - same clock and synchronous reset as the parent.
- The FSM, baud counter, address decode and drop counter live in `mmio_uart_tx`.

## Test plan
- Reset, then store 8'h55 to 32'h0000_FF00 with `CLKS_PER_BIT` = 4:
  - `tx` falls 2 cycles later;
  - bits sample 1,0,1,0,1,0,1,0 (LSB first) every 4 cycles;
  - stop bit is high;
  - `busy` drops after 40 cycles.
- Store to 32'h0000_FF04 and a read cycle at `TX_ADDR`: no frame is sent and `busy` stays 0.
- 6 consecutive stores (bytes 1..6) with `FIFO_DEPTH` = 4:
  - the first pops immediately, so 5 are accepted;
  - `drop_cnt` = 1;
  - bytes 1..5 are transmitted in order, each separated by one idle cycle.
- Store while full on the same cycle as a pop: the byte is accepted, `drop_cnt` is unchanged, and `fifo_full` stays 1.
- Assert `reset` during DATA bit 3: `tx` = 1 after the edge, `busy` = 0, and no further frame is sent.
- With `MMIO_UART_PARITY_EN`, send 8'h07: the parity bit is 1 and the frame is 11×`CLKS_PER_BIT` cycles long.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants and the serializer state type for the memory-mapped UART transmitter.
package mmio_pkg;

    localparam logic [31:0] TX_ADDR_DEFAULT = 32'h0000_FF00;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head output; push is ignored when full
// unless a pop happens on the same edge, and pop is ignored when empty.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         din,
    output logic [Width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Store-snooping UART transmitter: stores to TX_ADDR are queued and sent as 8N1 frames.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enab,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

    uart_state_e      state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             push_req, pop, baud_tc;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CntW-1:0]  fifo_count;
    logic             unused_wdata;

    assign unused_wdata = ^write_data[31:8];
    assign push_req     = write_enab && (data_addr == TX_ADDR);
    assign baud_tc      = (baud_q == BaudW'(CLKS_PER_BIT - 1));

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (push_req && fifo_full && !pop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // tx_d reflects the current state; registering it gives the one-cycle output delay.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        pop       = 1'b0;
        tx_d      = 1'b1;
        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_dout;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_d   = 1'b0;
                baud_d = baud_tc ? '0 : baud_q + 1'b1;
                if (baud_tc) begin
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                tx_d   = data_q[bit_idx_q];
                baud_d = baud_tc ? '0 : baud_q + 1'b1;
                if (baud_tc) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            StParity: begin
                tx_d   = ^data_q;
                baud_d = baud_tc ? '0 : baud_q + 1'b1;
                if (baud_tc) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                baud_d = baud_tc ? '0 : baud_q + 1'b1;
                if (baud_tc) begin
                    state_d = StIdle;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tx       = tx_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] TXA   = 32'h0000_FF00;
    localparam int          HLEN  = 230;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_enab;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [7:0]  drop_cnt;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        tx;
        logic        busy;
        logic        full;
        logic [7:0]  drop;
    } vec_t;

    vec_t vecs[$];
    logic hist [HLEN];

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .TX_ADDR      (TXA),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write_enab (write_enab),
        .data_addr  (data_addr),
        .write_data (write_data),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .drop_cnt   (drop_cnt)
    );

    // One rising edge: inputs change on the falling edge, outputs are read 1 time unit after.
    task automatic step(input logic rst, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        reset      = rst;
        write_enab = we;
        data_addr  = a;
        write_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        vec_t       v;
        logic [7:0] b55;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        int         s;
        int         bad;

        reset      = 1'b1;
        write_enab = 1'b0;
        data_addr  = 32'h0;
        write_data = 32'h0;

        // Frame of 8'h55: store at k=0, pop at k=1, tx low after k=2..5, bits every 4,
        // stop after k=38..41, IDLE (busy low) from k=41.
        b55 = 8'h55;
        for (int k = 0; k < 45; k++) begin
            v.we    = (k == 0);
            v.addr  = (k == 0) ? TXA : 32'h0;
            v.wdata = (k == 0) ? 32'hFFFF_FF55 : 32'h0;
            if (k < 2)       v.tx = 1'b1;
            else if (k < 6)  v.tx = 1'b0;
            else if (k < 38) v.tx = b55[(k - 6) / 4];
            else             v.tx = 1'b1;
            v.busy = (k <= 40);
            v.full = 1'b0;
            v.drop = 8'h00;
            vecs.push_back(v);
        end
        // Wrong address, read at TX_ADDR, upper address bits differing: all ignored.
        vecs.push_back('{1'b1, 32'h0000_FF04, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b0, TXA,           32'h0000_00AA, 1'b1, 1'b0, 1'b0, 8'h00});
        vecs.push_back('{1'b1, 32'h1000_FF00, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 8'h00});
        for (int k = 0; k < 10; k++) begin
            vecs.push_back('{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00});
        end

        step(1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 32'h0);
        check("reset_state", {21'h0, tx, busy, fifo_full, drop_cnt}, {21'h0, 11'b100_0000_0000});
        step(1'b0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d", i), {21'h0, tx, busy, fifo_full, drop_cnt},
                  {21'h0, vecs[i].tx, vecs[i].busy, vecs[i].full, vecs[i].drop});
        end

        // Six back-to-back stores: byte 1 pops at e1, 2..5 fill the FIFO, 6 is dropped.
        do_reset();
        for (int e = 0; e < HLEN; e++) begin
            if (e < 6) step(1'b0, 1'b1, TXA, 32'(e + 1));
            else       step(1'b0, 1'b0, 32'h0, 32'h0);
            hist[e] = tx;
            if (e == 4) check("ovf_full_e4", {fifo_full, drop_cnt}, {1'b1, 8'h00});
            if (e == 5) check("ovf_drop_e5", {fifo_full, drop_cnt}, {1'b1, 8'h01});
        end
        for (int j = 0; j < 5; j++) begin
            s = 2 + 41 * j;
            exp_b = 8'(j + 1);
            for (int i = 0; i < 8; i++) got_b[i] = hist[s + 6 + 4 * i];
            check($sformatf("frame%0d_start", j), {hist[s - 1], hist[s], hist[s + 3]}, 3'b100);
            check($sformatf("frame%0d_byte", j), got_b, exp_b);
            check($sformatf("frame%0d_stop", j), {hist[s + 36], hist[s + 39], hist[s + 40]},
                  3'b111);
        end
        bad = 0;
        for (int k = 2 + 41 * 4 + 36; k < HLEN; k++) if (hist[k] !== 1'b1) bad++;
        check("ovf_no_sixth_frame", bad, 0);
        check("ovf_end_state", {busy, fifo_full, drop_cnt}, {1'b0, 1'b0, 8'h01});

        // Store on the same edge as a pop while full: accepted, count and drop unchanged.
        do_reset();
        for (int e = 0; e < 5; e++) step(1'b0, 1'b1, TXA, 32'hA0 + 32'(e));
        check("simul_full_e4", {fifo_full, drop_cnt}, {1'b1, 8'h00});
        for (int e = 5; e < 42; e++) step(1'b0, 1'b0, 32'h0, 32'h0);
        check("simul_pre_e41", {tx, busy, fifo_full}, 3'b111);
        step(1'b0, 1'b1, TXA, 32'hA5);
        check("simul_push_pop_e42", {tx, fifo_full, drop_cnt}, {1'b1, 1'b1, 8'h00});
        step(1'b0, 1'b0, 32'h0, 32'h0);
        check("simul_start_e43", {tx, fifo_full}, 2'b01);
        step(1'b0, 1'b1, TXA, 32'hA6);
        check("simul_drop_e44", {fifo_full, drop_cnt}, {1'b1, 8'h01});

        // Reset during DATA bit 3 of 8'hC3 with 8'h3C queued behind it.
        do_reset();
        step(1'b0, 1'b1, TXA, 32'hC3);
        step(1'b0, 1'b1, TXA, 32'h3C);
        for (int e = 2; e < 18; e++) step(1'b0, 1'b0, 32'h0, 32'h0);
        check("midrst_bit2_e17", {tx, busy}, 2'b01);
        step(1'b1, 1'b0, 32'h0, 32'h0);
        check("midrst_after_edge", {tx, busy, fifo_full, drop_cnt}, {3'b100, 8'h00});
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            step(1'b0, 1'b0, 32'h0, 32'h0);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("midrst_quiet", bad, 0);

`ifdef MMIO_UART_PARITY_EN
        // 8'h07 has three ones: parity bit 1, samples after e38..e41, IDLE from e45.
        do_reset();
        for (int e = 0; e < 50; e++) begin
            if (e == 0) step(1'b0, 1'b1, TXA, 32'h07);
            else        step(1'b0, 1'b0, 32'h0, 32'h0);
            hist[e] = tx;
            if (e == 44) check("par_busy_e44", busy, 1'b1);
            if (e == 45) check("par_busy_e45", busy, 1'b0);
        end
        check("par_bit", {hist[37], hist[38], hist[41], hist[42]}, 4'b0111);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
